link_ddr_upstream_tx: RTL and testbench

Transmit end of the DDR link channel: accepts core words over a valid/ready handshake, serializes each into CH_W-bit beats on the io channel, and throttles on credits returned by the downstream receiver via a toggling token line. Sits between the core-side producer and the io pad/DDR launch logic, on a single clock domain clk. Each credit equals one receiver buffer entry (flit = 2 beats = 2*CH_W bits).

---
 rtl/link_ddr_pkg.sv | 21 ++
 rtl/link_token_credit_counter.sv | 46 ++++
 rtl/link_ddr_upstream_tx.sv | 92 +++++++++
 tb/tb_link_ddr_upstream_tx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/link_ddr_pkg.sv
// Shared types and width helpers for the DDR link transmit path.
package link_ddr_pkg;

    localparam int CH_W_DEF   = 8;
    localparam int CORE_W_DEF = 32;

    function automatic int beats_of(input int core_w, input int ch_w);
        return core_w / ch_w;
    endfunction

    // One flit is two beats, i.e. one receiver buffer entry.
    function automatic int flits_of(input int core_w, input int ch_w);
        return core_w / (2 * ch_w);
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_e;

endpackage

// File: rtl/link_token_credit_counter.sv
// Receiver credit tracking: token toggle detect, reserve on accept, saturate with sticky error.
module link_token_credit_counter #(
    parameter int CREDITS     = 16,
    parameter int TOKEN_FLITS = 4,
    parameter int FLITS       = 2,
    parameter int CW          = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          io_token_i,
    input  logic          consume_i,
    output logic [CW-1:0] credit_o,
    output logic          credit_ok_o,
    output logic          credit_err_o
);

    localparam logic [CW:0] CREDITS_W = (CW + 1)'(CREDITS);
    localparam logic [CW:0] TOKEN_W   = (CW + 1)'(TOKEN_FLITS);
    localparam logic [CW:0] FLITS_W   = (CW + 1)'(FLITS);

    logic        tok_q;
    logic        token_ret;
    logic [CW:0] credit_sum;

    // Add the return before the subtract so the intermediate never wraps.
    always_comb begin
        token_ret  = io_token_i != tok_q;
        credit_sum = {1'b0, credit_o} + (token_ret ? TOKEN_W : '0) - (consume_i ? FLITS_W : '0);
    end

    assign credit_ok_o = credit_o >= CW'(FLITS);

    always_ff @(posedge clk) begin
        tok_q <= io_token_i;
        if (rst) begin
            credit_o     <= CW'(CREDITS);
            credit_err_o <= 1'b0;
        end else if (credit_sum > CREDITS_W) begin
            credit_o     <= CW'(CREDITS);
            credit_err_o <= 1'b1;
        end else begin
            credit_o <= credit_sum[CW-1:0];
        end
    end

endmodule

// File: rtl/link_ddr_upstream_tx.sv
// DDR link transmit end: serializes core words into LSB-first channel beats under receiver credit.
//   state | meaning
//   IDLE  | no word in flight, io_valid_o low
//   SEND  | beat 'beat' of the current word is on io_data_o
module link_ddr_upstream_tx
    import link_ddr_pkg::*;
#(
    parameter int CORE_W      = CORE_W_DEF,
    parameter int CH_W        = CH_W_DEF,
    parameter int CREDITS     = 16,
    parameter int TOKEN_FLITS = 4,
    localparam int CW         = $clog2(CREDITS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CORE_W-1:0] core_data_i,
    input  logic              core_valid_i,
    output logic              core_ready_o,
    output logic [CH_W-1:0]   io_data_o,
    output logic              io_valid_o,
    input  logic              io_token_i,
    output logic [CW-1:0]     credit_o,
    output logic              credit_err_o,
    output logic              busy_o
);

    localparam int BEATS = beats_of(CORE_W, CH_W);
    localparam int FLITS = flits_of(CORE_W, CH_W);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    tx_state_e         state;
    logic [BW-1:0]     beat;
    logic [CORE_W-1:0] shift_reg;
    logic              credit_ok;
    logic              accept;

    assign core_ready_o = !rst && credit_ok &&
                          (state == IDLE || (state == SEND && beat == LAST_BEAT));
    assign accept       = core_valid_i && core_ready_o;
    assign busy_o       = state == SEND;

    link_token_credit_counter #(
        .CREDITS     (CREDITS),
        .TOKEN_FLITS (TOKEN_FLITS),
        .FLITS       (FLITS),
        .CW          (CW)
    ) u_credit (
        .clk          (clk),
        .rst          (rst),
        .io_token_i   (io_token_i),
        .consume_i    (accept),
        .credit_o     (credit_o),
        .credit_ok_o  (credit_ok),
        .credit_err_o (credit_err_o)
    );

    // Beat 0 is launched straight from core_data_i so it appears the cycle after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            beat       <= '0;
            shift_reg  <= '0;
            io_valid_o <= 1'b0;
            io_data_o  <= '0;
        end else if (accept) begin
            state      <= SEND;
            beat       <= '0;
            io_valid_o <= 1'b1;
            io_data_o  <= core_data_i[CH_W-1:0];
            shift_reg  <= core_data_i >> CH_W;
        end else begin
            case (state)
                SEND: begin
                    if (beat == LAST_BEAT) begin
                        state      <= IDLE;
                        beat       <= '0;
                        io_valid_o <= 1'b0;
                    end else begin
                        beat      <= beat + BW'(1);
                        io_data_o <= shift_reg[CH_W-1:0];
                        shift_reg <= shift_reg >> CH_W;
                    end
                end
                default: begin
                    io_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_link_ddr_upstream_tx.sv
// Scoreboard bench for link_ddr_upstream_tx: beats queued at acceptance, checked on the io side.
module tb_link_ddr_upstream_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] core_data_i = '0;
    logic        core_valid_i = 1'b0;
    logic        core_ready_o;
    logic [7:0]  io_data_o;
    logic        io_valid_o;
    logic        io_token_i = 1'b0;
    logic [4:0]  credit_o;
    logic        credit_err_o;
    logic        busy_o;

    typedef struct {
        logic [7:0] data;
        int         due;
    } beat_t;

    beat_t exp_q[$];
    int    cyc = 0;
    int    vectors = 0;
    int    miscompares = 0;
    int    beats_seen = 0;

    link_ddr_upstream_tx dut (
        .clk          (clk),
        .rst          (rst),
        .core_data_i  (core_data_i),
        .core_valid_i (core_valid_i),
        .core_ready_o (core_ready_o),
        .io_data_o    (io_data_o),
        .io_valid_o   (io_valid_o),
        .io_token_i   (io_token_i),
        .credit_o     (credit_o),
        .credit_err_o (credit_err_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor samples on the falling edge; the driver acts 1ns later.
    always @(negedge clk) begin
        if (io_valid_o) begin
            beats_seen++;
            chk("beat_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                chk("beat_data", io_data_o, exp_q[0].data);
                chk("beat_cycle", cyc, exp_q[0].due);
                void'(exp_q.pop_front());
            end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            chk("beat_missing", io_valid_o, 1);
            void'(exp_q.pop_front());
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        int n = 0;
        core_data_i  = w;
        core_valid_i = 1'b1;
        while (!core_ready_o && n < 64) begin
            tick();
            n++;
        end
        chk("ready_wait", n < 64, 1);
        if (n < 64)
            for (int k = 0; k < 4; k++)
                exp_q.push_back('{data: w[k*8 +: 8], due: cyc + 1 + k});
        tick();
    endtask

    task automatic drain(input int n);
        core_valid_i = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        // Reset state
        tick();
        tick();
        chk("ready_in_rst", core_ready_o, 0);
        rst = 1'b0;
        tick();
        chk("rst_valid", io_valid_o, 0);
        chk("rst_data", io_data_o, 0);
        chk("rst_credit", credit_o, 16);
        chk("rst_err", credit_err_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("idle_ready", core_ready_o, 1);

        // Single word
        base = beats_seen;
        send(32'hDDCCBBAA);
        chk("credit_single", credit_o, 14);
        chk("busy_single", busy_o, 1);
        drain(6);
        chk("beats_single", beats_seen - base, 4);

        // Eight words back-to-back from full credit, then a held ninth
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("credit_refill", credit_o, 16);
        base = beats_seen;
        for (int i = 0; i < 8; i++) send(32'h1000_0001 * (i + 1) ^ 32'h5A3C_96E1);
        chk("credit_empty", credit_o, 0);
        core_data_i  = 32'hFEED_BEEF;
        core_valid_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk("ready_stalled", core_ready_o, 0);
            tick();
        end
        chk("beats_burst", beats_seen - base, 32);
        chk("credit_still_empty", credit_o, 0);

        // One token from empty
        core_valid_i = 1'b0;
        io_token_i = ~io_token_i;
        tick();
        chk("credit_token", credit_o, 4);
        chk("ready_after_token", core_ready_o, 1);
        send(32'h0123_4567);
        send(32'h89AB_CDEF);
        chk("credit_two_words", credit_o, 0);
        drain(6);

        // Consume and return in the same cycle at credit 2
        io_token_i = ~io_token_i;
        tick();
        send(32'hCAFE_F00D);
        drain(6);
        chk("credit_two", credit_o, 2);
        io_token_i = ~io_token_i;
        send(32'h7654_3210);
        chk("credit_simul", credit_o, 4);
        drain(6);

        // Overflow saturates and latches the error
        for (int i = 0; i < 3; i++) begin
            io_token_i = ~io_token_i;
            tick();
        end
        chk("credit_full", credit_o, 16);
        chk("err_before_ovf", credit_err_o, 0);
        io_token_i = ~io_token_i;
        tick();
        chk("credit_sat", credit_o, 16);
        chk("err_ovf", credit_err_o, 1);
        drain(5);
        chk("err_sticky", credit_err_o, 1);

        // Reset during beat 2 of a word, with the token moving under reset
        send(32'hA1B2_C3D4);
        core_valid_i = 1'b0;
        tick();
        tick();
        chk("mid_valid", io_valid_o, 1);
        rst = 1'b1;
        io_token_i = ~io_token_i;
        while (exp_q.size() > 0 && exp_q[$].due > cyc) void'(exp_q.pop_back());
        tick();
        chk("abort_valid", io_valid_o, 0);
        chk("abort_credit", credit_o, 16);
        chk("abort_err", credit_err_o, 0);
        rst = 1'b0;
        tick();
        tick();
        chk("post_rst_credit", credit_o, 16);
        chk("post_rst_err", credit_err_o, 0);
        chk("post_rst_valid", io_valid_o, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
